// File: rtl/keccak_padder_if.sv
// Byte-stream feeder bus between message source, padder and the permutation.
// The master side supplies message words and the permutation ack; the slave
// side (the padder) returns back-pressure and the assembled rate block.
interface keccak_padder_if;
    logic [31:0]  in;
    logic         in_ready;
    logic         is_last;
    logic [1:0]   byte_num;
    logic         buffer_full;
    logic [575:0] out;
    logic         out_ready;
    logic         f_ack;

    modport master (
        output in, in_ready, is_last, byte_num, f_ack,
        input  buffer_full, out, out_ready
    );

    modport slave (
        input  in, in_ready, is_last, byte_num, f_ack,
        output buffer_full, out, out_ready
    );
endinterface

// File: rtl/keccak_padder.sv
// Keccak padder: packs 32-bit message words into 576-bit rate blocks
// (18 words) and applies multi-rate padding after the final message byte.
// A completed block is held until the permutation acknowledges it.
module keccak_padder #(
    parameter logic [7:0] PAD_FIRST = 8'h01,
    parameter logic [7:0] PAD_LAST  = 8'h80
) (
    input  logic            clk,
    input  logic            reset,
    keccak_padder_if.slave  bus
);
    typedef enum logic [1:0] {ACCUM, PAD, FULL, DONE} state_t;

    localparam logic [4:0] LAST_IDX = 5'd17;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [4:0]   r_cnt;
    logic [575:0] r_out;
    logic         r_pend;

    logic         w_load;
    logic [31:0]  w_word;
    logic [31:0]  w_last_word;
    logic         w_set_pend;
    logic         w_clr_cnt;

    // Final message word: keep the top byte_num bytes, then the domain pad
    // byte, zeros below; word 17 also carries the closing pad bit.
    always_comb begin
        w_last_word = 32'h0;
        case (bus.byte_num)
            2'd0: w_last_word = {PAD_FIRST, 24'h0};
            2'd1: w_last_word = {bus.in[31:24], PAD_FIRST, 16'h0};
            2'd2: w_last_word = {bus.in[31:16], PAD_FIRST, 8'h0};
            default: w_last_word = {bus.in[31:8], PAD_FIRST};
        endcase
        if (r_cnt == LAST_IDX)
            w_last_word[7:0] = w_last_word[7:0] | PAD_LAST;
    end

    // Next-state and load control; the shift register only moves on w_load.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_word      = bus.in;
        w_set_pend  = 1'b0;
        w_clr_cnt   = 1'b0;
        case (r_state)
            ACCUM: begin
                if (bus.in_ready) begin
                    w_load = 1'b1;
                    if (bus.is_last) begin
                        w_word      = w_last_word;
                        w_set_pend  = 1'b1;
                        w_state_nxt = (r_cnt == LAST_IDX) ? FULL : PAD;
                    end else if (r_cnt == LAST_IDX) begin
                        w_state_nxt = FULL;
                    end
                end
            end
            PAD: begin
                w_load = 1'b1;
                w_word = (r_cnt == LAST_IDX) ? {24'h0, PAD_LAST} : 32'h0;
                if (r_cnt == LAST_IDX)
                    w_state_nxt = FULL;
            end
            FULL: begin
                // Input offered in the ack cycle is refused: buffer_full is
                // still high, so the next accept is one cycle later.
                if (bus.f_ack) begin
                    w_clr_cnt   = 1'b1;
                    w_state_nxt = r_pend ? DONE : ACCUM;
                end
            end
            default: ;
        endcase
    end

    // State, word counter, block shift register and final-message flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ACCUM;
            r_cnt   <= 5'd0;
            r_out   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_out <= {r_out[543:0], w_word};
                r_cnt <= r_cnt + 5'd1;
            end else if (w_clr_cnt) begin
                r_cnt <= 5'd0;
            end
            if (w_set_pend)
                r_pend <= 1'b1;
        end
    end

    assign bus.buffer_full = (r_state != ACCUM);
    assign bus.out_ready   = (r_state == FULL);
    assign bus.out         = r_out;
endmodule

// File: tb/tb_keccak_padder.sv
// Bench for keccak_padder: byte-level reference model feeding a scoreboard
// of expected blocks, a vector table of final-word cases, and hand-written
// multi-block / back-pressure / reset / spurious-ack sequences.
module tb_keccak_padder;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    keccak_padder_if bus();

    keccak_padder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: message bytes collected per block, padded at byte level.
    logic [7:0]   mb[$];
    logic [575:0] exp_q[$];
    logic [575:0] last_blk;
    logic         or_q = 1'b0;

    function automatic void model_word(input logic [31:0] w, input logic last,
                                       input logic [1:0] bn);
        logic [575:0] blk;
        int nb;
        nb = last ? int'(bn) : 4;
        for (int i = 0; i < nb; i++) mb.push_back(w[31-8*i -: 8]);
        if (last) begin
            mb.push_back(8'h01);
            while (mb.size() < 72) mb.push_back(8'h00);
            mb[71] = mb[71] | 8'h80;
        end
        if (mb.size() == 72) begin
            blk = '0;
            for (int i = 0; i < 72; i++) blk[575-8*i -: 8] = mb[i];
            exp_q.push_back(blk);
            mb.delete();
        end
    endfunction

    task automatic check(input string name, input logic [575:0] act, input logic [575:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act[127:0], req[127:0]);
        end
    endtask

    function automatic logic [31:0] wd(input int k);
        return bus.out[575-32*k -: 32];
    endfunction

    // Scoreboard: every rising out_ready must deliver the next expected block.
    always @(negedge clk) begin
        if (!reset && bus.out_ready && !or_q) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_block: got %h", bus.out[127:0]);
            end else begin
                last_blk = exp_q.pop_front();
                if (bus.out !== last_blk) begin
                    n_fail++;
                    $display("FAIL sb_block: got %h want %h", bus.out, last_blk);
                end
            end
        end
        or_q <= bus.out_ready & ~reset;
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mb.delete();
    endtask

    // Present one word until accepted (bounded), then retire it to the model.
    task automatic send(input logic [31:0] w, input logic last, input logic [1:0] bn);
        int g;
        g = 0;
        bus.in = w; bus.is_last = last; bus.byte_num = bn; bus.in_ready = 1'b1;
        @(negedge clk);
        while (bus.buffer_full && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: buffer_full stuck 1 want 0");
        end
        @(posedge clk); #1;
        bus.in_ready = 1'b0; bus.is_last = 1'b0;
        model_word(w, last, bn);
    endtask

    // Count clock edges from the accept edge until out_ready appears.
    task automatic wait_ready(output int lat);
        lat = 0;
        while (!bus.out_ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack(input logic bf_exp);
        bus.f_ack = 1'b1;
        @(posedge clk); #1;
        bus.f_ack = 1'b0;
        check("ack_out_ready_low", 576'(bus.out_ready), 576'(1'b0));
        check("ack_buffer_full", 576'(bus.buffer_full), 576'(bf_exp));
    endtask

    typedef struct {
        int          nfill;
        logic [31:0] w;
        logic [1:0]  bn;
        int          lat;
        logic [31:0] exp_w;
        logic [31:0] exp_w17;
    } vec_t;

    vec_t vecs[7];
    int   lat;

    initial begin
        bus.in = '0; bus.in_ready = 0; bus.is_last = 0; bus.byte_num = 0; bus.f_ack = 0;
        reset = 1'b1;
        @(posedge clk); #1;

        vecs[0] = '{0,  32'hCAFEBABE, 2'd0, 17, 32'h01000000, 32'h00000080};
        vecs[1] = '{17, 32'h11223344, 2'd3, 0,  32'h11223381, 32'h11223381};
        vecs[2] = '{0,  32'hDEADBEEF, 2'd2, 17, 32'hDEAD0100, 32'h00000080};
        vecs[3] = '{5,  32'hAABBCCDD, 2'd1, 12, 32'hAA010000, 32'h00000080};
        vecs[4] = '{16, 32'h01020304, 2'd3, 1,  32'h01020301, 32'h00000080};
        vecs[5] = '{17, 32'h55667788, 2'd0, 0,  32'h01000080, 32'h01000080};
        vecs[6] = '{17, 32'h9ABCDEF0, 2'd1, 0,  32'h9A010080, 32'h9A010080};

        for (int v = 0; v < 7; v++) begin
            do_reset();
            check("rst_out", bus.out, '0);
            check("rst_out_ready", 576'(bus.out_ready), 576'(1'b0));
            check("rst_buffer_full", 576'(bus.buffer_full), 576'(1'b0));
            for (int i = 0; i < vecs[v].nfill; i++) send(32'hA5A5A5A5, 1'b0, 2'd0);
            send(vecs[v].w, 1'b1, vecs[v].bn);
            wait_ready(lat);
            check("vec_latency", 576'(lat), 576'(vecs[v].lat));
            check("vec_last_word", 576'(wd(vecs[v].nfill)), 576'(vecs[v].exp_w));
            check("vec_word17", 576'(wd(17)), 576'(vecs[v].exp_w17));
            check("vec_buffer_full", 576'(bus.buffer_full), 576'(1'b1));
            ack(1'b1);
            repeat (3) @(posedge clk);
            #1 check("done_holds", 576'({bus.buffer_full, bus.out_ready}), 576'(2'b10));
        end

        // Multi-block with back-pressure and input held across the ack.
        do_reset();
        for (int i = 1; i <= 18; i++) send(32'(i), 1'b0, 2'd0);
        check("mb_ready", 576'(bus.out_ready), 576'(1'b1));
        check("mb_word0", 576'(wd(0)), 576'(32'h1));
        check("mb_word17", 576'(wd(17)), 576'(32'h12));
        check("mb_buffer_full", 576'(bus.buffer_full), 576'(1'b1));
        bus.in = 32'h77777777; bus.in_ready = 1'b1; bus.is_last = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_out_stable", bus.out, last_blk);
            check("bp_ready_full", 576'({bus.out_ready, bus.buffer_full}), 576'(2'b11));
        end
        bus.in = 32'hDEADBEEF; bus.is_last = 1'b1; bus.byte_num = 2'd2; bus.f_ack = 1'b1;
        @(posedge clk); #1;
        bus.f_ack = 1'b0;
        check("mb_ack_ready_low", 576'(bus.out_ready), 576'(1'b0));
        check("mb_ack_not_taken", 576'(wd(17)), 576'(32'h12));
        check("mb_ack_bf_low", 576'(bus.buffer_full), 576'(1'b0));
        @(posedge clk); #1;
        bus.in_ready = 1'b0; bus.is_last = 1'b0;
        model_word(32'hDEADBEEF, 1'b1, 2'd2);
        check("mb_taken_next", 576'(wd(17)), 576'(32'hDEAD0100));
        wait_ready(lat);
        check("mb2_latency", 576'(lat), 576'(17));
        check("mb2_word0", 576'(wd(0)), 576'(32'hDEAD0100));
        check("mb2_word17", 576'(wd(17)), 576'(32'h80));
        ack(1'b1);

        // Reset mid-block discards partial data; a fresh block assembles.
        do_reset();
        for (int i = 0; i < 7; i++) send(32'h10000000 + 32'(i), 1'b0, 2'd0);
        do_reset();
        check("mid_rst_out", bus.out, '0);
        check("mid_rst_flags", 576'({bus.out_ready, bus.buffer_full}), 576'(2'b00));
        send(32'h0BADF00D, 1'b1, 2'd3);
        wait_ready(lat);
        check("mid_rst_latency", 576'(lat), 576'(17));
        check("mid_rst_word0", 576'(wd(0)), 576'(32'h0BADF001));
        ack(1'b1);

        // Spurious ack in ACCUM must not disturb the count.
        do_reset();
        for (int i = 0; i < 5; i++) send(32'h20000000 + 32'(i), 1'b0, 2'd0);
        bus.f_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.f_ack = 1'b0;
        check("spur_bf", 576'(bus.buffer_full), 576'(1'b0));
        for (int i = 5; i < 17; i++) send(32'h20000000 + 32'(i), 1'b0, 2'd0);
        check("spur_not_ready_17", 576'(bus.out_ready), 576'(1'b0));
        send(32'h20000011, 1'b0, 2'd0);
        check("spur_ready_18", 576'(bus.out_ready), 576'(1'b1));
        check("spur_word0", 576'(wd(0)), 576'(32'h20000000));
        ack(1'b0);

        @(negedge clk);
        check("sb_drained", 576'(exp_q.size()), 576'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
